// File: rtl/galaksija_tape_rec_if.sv
// Tape recorder bus: tick enable, tape level, arm strobe, upload read port and status.
interface galaksija_tape_rec_if #(
  parameter int AW = 14
);
  logic          ce;
  logic          tape_lvl;
  logic          arm;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [AW:0]   byte_count;
  logic          recording;
  logic          done;
  logic          overflow;

  modport master (
    output ce, tape_lvl, arm, rd_addr,
    input  rd_data, byte_count, recording, done, overflow
  );

  modport slave (
    input  ce, tape_lvl, arm, rd_addr,
    output rd_data, byte_count, recording, done, overflow
  );
endinterface

// File: rtl/galaksija_tape_rec.sv
// Galaksija cassette-save decoder: turns the CPU-driven tape level back into
// bytes (pulse-position cells, LSB first) and captures them for ioctl upload.
module galaksija_tape_rec #(
  parameter int AW       = 14,
  parameter int MIN_GAP  = 500,
  parameter int HALF_THR = 6900,
  parameter int TIMEOUT  = 200000
) (
  input logic clk,
  input logic reset,
  galaksija_tape_rec_if.slave bus
);
  localparam int CW = 18;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] GAP_C   = CW'(MIN_GAP);
  localparam logic [CW-1:0] HALF_C  = CW'(HALF_THR);
  localparam logic [CW-1:0] TO_C    = CW'(TIMEOUT);
  localparam logic [AW:0]   FULL    = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, WAIT_START, IN_CELL, WAIT_NEXT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [6:0]    sh;       // first seven bits of the byte, bit 0 ends up in sh[0]
  logic [2:0]    bidx;
  logic          lvl_q;
  logic [AW:0]   byte_count;
  logic          recording, done, overflow;
  logic [7:0]    rd_data;

  logic [7:0] mem [0:(1<<AW)-1];

  logic          fe, fe_ok, hit_half, hit_to, commit, bit_val, byte_done, full, we;
  logic [CW-1:0] cnt_inc;
  logic [7:0]    byte_val;

  // Edge detection, glitch filter and commit decisions for the current ce tick.
  always_comb begin
    fe        = bus.ce & lvl_q & ~bus.tape_lvl;
    fe_ok     = fe & (state != IDLE) & ((cnt >= GAP_C) | (state == WAIT_START));
    cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    hit_half  = cnt_inc >= HALF_C;
    hit_to    = cnt_inc >= TO_C;
    // a mid-cell edge wins over the half threshold in the same tick
    commit    = bus.ce & (state == IN_CELL) & (fe_ok | hit_half);
    bit_val   = fe_ok;
    byte_val  = {bit_val, sh};
    byte_done = commit & (bidx == 3'd7);
    full      = byte_count == FULL;
    we        = byte_done & ~full & ~bus.arm;
  end

  // Capture FSM, interval counter and status registers; arm overrides everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sh         <= '0;
      bidx       <= '0;
      lvl_q      <= 1'b1;
      byte_count <= '0;
      recording  <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (bus.ce) begin
        lvl_q <= bus.tape_lvl;
        cnt   <= fe_ok ? '0 : cnt_inc;
      end
      if (bus.arm) begin
        state      <= WAIT_START;
        byte_count <= '0;
        done       <= 1'b0;
        overflow   <= 1'b0;
        recording  <= 1'b1;
        bidx       <= '0;
        sh         <= '0;
      end else if (bus.ce) begin
        case (state)
          WAIT_START: if (fe_ok) state <= IN_CELL;
          IN_CELL: if (commit) begin
            sh    <= {bit_val, sh[6:1]};
            bidx  <= bidx + 3'd1;
            state <= WAIT_NEXT;
            if (byte_done) begin
              if (full) begin
                overflow  <= 1'b1;
                recording <= 1'b0;
                state     <= IDLE;
              end else begin
                byte_count <= byte_count + 1'b1;
              end
            end
          end
          WAIT_NEXT: begin
            if (fe_ok) state <= IN_CELL;
            else if (hit_to) begin
              // silence ends the recording; any partial byte is dropped
              state     <= IDLE;
              recording <= 1'b0;
              bidx      <= '0;
              if (byte_count != '0) done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Capture buffer write port; contents survive reset and arm.
  always_ff @(posedge clk) begin
    if (we) mem[byte_count[AW-1:0]] <= byte_val;
  end

  // Registered upload read; a same-cycle write to the address yields old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[bus.rd_addr];
  end

  assign bus.rd_data    = rd_data;
  assign bus.byte_count = byte_count;
  assign bus.recording  = recording;
  assign bus.done       = done;
  assign bus.overflow   = overflow;
endmodule

// File: tb/tb_galaksija_tape_rec.sv
// Directed bench for galaksija_tape_rec using time-scaled playback timing.
module tb_galaksija_tape_rec;
  localparam int MG   = 20;
  localparam int HT   = 69;
  localparam int TO   = 2000;
  localparam int CELL = 92;
  localparam int MID  = 46;
  localparam int PW   = 4;
  localparam int BGAP = 40;

  logic clk, reset;
  logic ce, lvl, arm0, arm4;
  logic [13:0] rd0;
  logic [3:0]  rd4;
  int total, bad;

  galaksija_tape_rec_if #(.AW(14)) bus0 ();
  galaksija_tape_rec_if #(.AW(4))  bus4 ();

  assign bus0.ce = ce;  assign bus0.tape_lvl = lvl;  assign bus0.arm = arm0;  assign bus0.rd_addr = rd0;
  assign bus4.ce = ce;  assign bus4.tape_lvl = lvl;  assign bus4.arm = arm4;  assign bus4.rd_addr = rd4;

  galaksija_tape_rec #(.AW(14), .MIN_GAP(MG), .HALF_THR(HT), .TIMEOUT(TO))
    u_dut (.clk(clk), .reset(reset), .bus(bus0));
  galaksija_tape_rec #(.AW(4), .MIN_GAP(MG), .HALF_THR(HT), .TIMEOUT(TO))
    u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // one bit cell; optional 1-tick glitch 10 ticks after the cell-start pulse
  task automatic send_cell(input logic b, input logic glitch);
    lvl = 1'b0; tick(PW); lvl = 1'b1;
    if (glitch) begin
      tick(10 - PW); lvl = 1'b0; tick(1); lvl = 1'b1; tick(MID - 11);
    end else tick(MID - PW);
    if (b) begin
      lvl = 1'b0; tick(PW); lvl = 1'b1; tick(CELL - MID - PW);
    end else tick(CELL - MID);
  endtask

  task automatic send_byte(input logic [7:0] v, input int gcell);
    for (int i = 0; i < 8; i++) send_cell(v[i], i == gcell);
    tick(BGAP);
  endtask

  task automatic pulse_arm0();
    arm0 = 1'b1; tick(1); arm0 = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [13:0] a, input logic [7:0] exp);
    rd0 = a; tick(1);
    chk(tag, {24'd0, bus0.rd_data}, {24'd0, exp});
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; ce = 1'b1; lvl = 1'b1; arm0 = 1'b0; arm4 = 1'b0; rd0 = '0; rd4 = '0;
    #12;
    chk("rst_count", 32'(bus0.byte_count), 0);
    chk("rst_rec",   32'(bus0.recording), 0);
    chk("rst_done",  32'(bus0.done), 0);
    chk("rst_ovf",   32'(bus0.overflow), 0);
    chk("rst_rd",    32'(bus0.rd_data), 0);
    @(posedge clk); #1; reset = 1'b0;
    tick(2);

    // single byte then silence
    pulse_arm0();
    chk("a5_rec_on", 32'(bus0.recording), 1);
    send_byte(8'hA5, -1);
    chk("a5_count", 32'(bus0.byte_count), 1);
    tick(TO + 500);
    chk("a5_done", 32'(bus0.done), 1);
    chk("a5_rec_off", 32'(bus0.recording), 0);
    chk("a5_count2", 32'(bus0.byte_count), 1);
    rd_chk("a5_buf0", 14'd0, 8'hA5);

    // back-to-back bytes
    pulse_arm0();
    chk("b2b_done_clr", 32'(bus0.done), 0);
    chk("b2b_cnt_clr", 32'(bus0.byte_count), 0);
    send_byte(8'h00, -1);
    send_byte(8'hFF, -1);
    send_byte(8'h01, -1);
    chk("b2b_count", 32'(bus0.byte_count), 3);
    rd_chk("b2b_buf0", 14'd0, 8'h00);
    rd_chk("b2b_buf1", 14'd1, 8'hFF);
    rd_chk("b2b_buf2", 14'd2, 8'h01);

    // glitch inside a 0-bit cell is filtered
    pulse_arm0();
    send_byte(8'h5A, 0);
    chk("glitch_count", 32'(bus0.byte_count), 1);
    rd_chk("glitch_buf0", 14'd0, 8'h5A);

    // overflow on the 16-byte instance
    arm4 = 1'b1; tick(1); arm4 = 1'b0;
    for (int i = 0; i < 17; i++) send_byte(8'(i * 17 + 3), -1);
    chk("ovf_count", 32'(bus4.byte_count), 16);
    chk("ovf_flag", 32'(bus4.overflow), 1);
    chk("ovf_rec", 32'(bus4.recording), 0);
    rd4 = 4'd15; tick(1);
    chk("ovf_buf15", 32'(bus4.rd_data), 32'h02);
    rd4 = 4'd0; tick(1);
    chk("ovf_buf0", 32'(bus4.rd_data), 32'h03);

    // re-arm mid-byte aborts the partial byte
    pulse_arm0();
    send_cell(1'b1, 1'b0); send_cell(1'b0, 1'b0); send_cell(1'b1, 1'b0);
    pulse_arm0();
    send_byte(8'h3C, -1);
    chk("rearm_count", 32'(bus0.byte_count), 1);
    rd_chk("rearm_buf0", 14'd0, 8'h3C);

    // ce held low in WAIT_NEXT freezes everything
    pulse_arm0();
    send_cell(1'b0, 1'b0); send_cell(1'b1, 1'b0); send_cell(1'b1, 1'b0); send_cell(1'b0, 1'b0);
    ce = 1'b0;
    tick(TO + 1000);
    chk("ce_rec", 32'(bus0.recording), 1);
    chk("ce_done", 32'(bus0.done), 0);
    chk("ce_count", 32'(bus0.byte_count), 0);
    ce = 1'b1;
    send_cell(1'b1, 1'b0); send_cell(1'b0, 1'b0); send_cell(1'b0, 1'b0); send_cell(1'b1, 1'b0);
    tick(BGAP);
    chk("ce_count2", 32'(bus0.byte_count), 1);
    rd_chk("ce_buf0", 14'd0, 8'h96);

    // asynchronous reset mid-capture
    pulse_arm0();
    send_byte(8'hC3, -1);
    send_cell(1'b1, 1'b0); send_cell(1'b0, 1'b0);
    rd_chk("rst2_pre_rd", 14'd0, 8'hC3);
    chk("rst2_pre_rec", 32'(bus0.recording), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst2_count", 32'(bus0.byte_count), 0);
    chk("rst2_rec", 32'(bus0.recording), 0);
    chk("rst2_done", 32'(bus0.done), 0);
    chk("rst2_ovf", 32'(bus0.overflow), 0);
    chk("rst2_rd", 32'(bus0.rd_data), 0);
    chk("rst2_ovf4", 32'(bus4.overflow), 0);
    tick(2);
    reset = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
